// File: rtl/itlb_refill_ctrl_if.sv
// PTW request/response channel between the ITLB refill controller (master) and the walker.
interface itlb_refill_ctrl_if #(
   parameter int unsigned ASID_WD = 9,
   parameter int unsigned VPN_WD  = 20,
   parameter int unsigned PPN_WD  = 22
);
   logic               ptw_req_valid;
   logic               ptw_req_ready;
   logic [ASID_WD-1:0] ptw_req_asid;
   logic [VPN_WD-1:0]  ptw_req_vpn;
   logic               ptw_resp_valid;
   logic [PPN_WD-1:0]  ptw_resp_ppn;
   logic               ptw_resp_g;
   logic               ptw_resp_fault;

   modport master (
      output ptw_req_valid, ptw_req_asid, ptw_req_vpn,
      input  ptw_req_ready, ptw_resp_valid, ptw_resp_ppn, ptw_resp_g, ptw_resp_fault
   );

   modport slave (
      input  ptw_req_valid, ptw_req_asid, ptw_req_vpn,
      output ptw_req_ready, ptw_resp_valid, ptw_resp_ppn, ptw_resp_g, ptw_resp_fault
   );
endinterface

// File: rtl/itlb_refill_ctrl.sv
// ITLB miss/refill controller: detects a lookup miss, runs a PTW request and writes
// the translation into a victim CAM line (first invalid line, else round-robin).
module itlb_refill_ctrl #(
   parameter int unsigned NUM_ENTRIES = 8,
   parameter int unsigned ASID_WD     = 9,
   parameter int unsigned VPN_WD      = 20,
   parameter int unsigned PPN_WD      = 22
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   tlb_flush_i,
   input  logic                   lookup_valid_i,
   input  logic [ASID_WD-1:0]     lookup_asid_i,
   input  logic [VPN_WD-1:0]      lookup_vpn_i,
   input  logic [NUM_ENTRIES-1:0] hit_vec_i,
   input  logic [NUM_ENTRIES-1:0] valid_vec_i,
   output logic                   busy_o,
   itlb_refill_ctrl_if.master     ptw,
   output logic [NUM_ENTRIES-1:0] fill_we_o,
   output logic [ASID_WD-1:0]     fill_asid_o,
   output logic [VPN_WD-1:0]      fill_vpn_o,
   output logic [PPN_WD-1:0]      fill_ppn_o,
   output logic                   fill_g_o,
   output logic                   fault_o
);

   localparam int unsigned IdxW = $clog2(NUM_ENTRIES);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StFill} state_e;

   state_e             state_q, state_d;
   logic [ASID_WD-1:0] asid_q, asid_d;
   logic [VPN_WD-1:0]  vpn_q, vpn_d;
   logic [PPN_WD-1:0]  ppn_q, ppn_d;
   logic               g_q, g_d;
   logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
   logic               drop_q, drop_d;
   logic               fault_q, fault_d;

   logic               drop_eff;
   logic               free_found;
   logic [IdxW-1:0]    free_idx;
   logic [IdxW-1:0]    victim_idx;

   // A flush arriving together with the response must also discard it.
   assign drop_eff = drop_q | tlb_flush_i;

   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (!valid_vec_i[i]) begin
            free_found = 1'b1;
            free_idx   = IdxW'(i);
         end
      end
      victim_idx = free_found ? free_idx : rr_ptr_q;
   end

   always_comb begin
      state_d   = state_q;
      asid_d    = asid_q;
      vpn_d     = vpn_q;
      ppn_d     = ppn_q;
      g_d       = g_q;
      rr_ptr_d  = rr_ptr_q;
      drop_d    = drop_q;
      fault_d   = 1'b0;
      fill_we_o = '0;

      unique case (state_q)
         StIdle: begin
            if (lookup_valid_i && (hit_vec_i == '0) && !tlb_flush_i) begin
               asid_d  = lookup_asid_i;
               vpn_d   = lookup_vpn_i;
               state_d = StReq;
            end
         end
         StReq: begin
            if (tlb_flush_i) drop_d = 1'b1;
            if (ptw.ptw_req_ready) state_d = StWait;
         end
         StWait: begin
            if (tlb_flush_i) drop_d = 1'b1;
            if (ptw.ptw_resp_valid) begin
               if (ptw.ptw_resp_fault || drop_eff) begin
                  fault_d = ptw.ptw_resp_fault & ~drop_eff;
                  state_d = StIdle;
               end else begin
                  ppn_d   = ptw.ptw_resp_ppn;
                  g_d     = ptw.ptw_resp_g;
                  state_d = StFill;
               end
            end
         end
         StFill: begin
            if (!tlb_flush_i) begin
               fill_we_o = NUM_ENTRIES'(1) << victim_idx;
               if (!free_found) rr_ptr_d = rr_ptr_q + IdxW'(1);
            end
            state_d = StIdle;
         end
      endcase

      if (tlb_flush_i) rr_ptr_d = '0;
      if (state_d == StIdle) drop_d = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         asid_q   <= '0;
         vpn_q    <= '0;
         ppn_q    <= '0;
         g_q      <= 1'b0;
         rr_ptr_q <= '0;
         drop_q   <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         asid_q   <= asid_d;
         vpn_q    <= vpn_d;
         ppn_q    <= ppn_d;
         g_q      <= g_d;
         rr_ptr_q <= rr_ptr_d;
         drop_q   <= drop_d;
         fault_q  <= fault_d;
      end
   end

   assign busy_o            = (state_q != StIdle);
   assign ptw.ptw_req_valid = (state_q == StReq);
   assign ptw.ptw_req_asid  = asid_q;
   assign ptw.ptw_req_vpn   = vpn_q;
   assign fill_asid_o       = asid_q;
   assign fill_vpn_o        = vpn_q;
   assign fill_ppn_o        = ppn_q;
   assign fill_g_o          = g_q;
   assign fault_o           = fault_q;

endmodule

// File: tb/tb_itlb_refill_ctrl.sv
// Directed bench for itlb_refill_ctrl: inputs change on the falling edge, outputs are
// checked 1 ns later, so every check sees the state left by the preceding rising edge.
module tb_itlb_refill_ctrl;

   localparam int unsigned NUM_ENTRIES = 8;
   localparam int unsigned ASID_WD     = 9;
   localparam int unsigned VPN_WD      = 20;
   localparam int unsigned PPN_WD      = 22;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   tlb_flush;
   logic                   lookup_valid;
   logic [ASID_WD-1:0]     lookup_asid;
   logic [VPN_WD-1:0]      lookup_vpn;
   logic [NUM_ENTRIES-1:0] hit_vec;
   logic [NUM_ENTRIES-1:0] valid_vec;
   logic                   busy;
   logic [NUM_ENTRIES-1:0] fill_we;
   logic [ASID_WD-1:0]     fill_asid;
   logic [VPN_WD-1:0]      fill_vpn;
   logic [PPN_WD-1:0]      fill_ppn;
   logic                   fill_g;
   logic                   fault;

   int n_checks = 0;
   int n_pass   = 0;

   itlb_refill_ctrl_if #(.ASID_WD(ASID_WD), .VPN_WD(VPN_WD), .PPN_WD(PPN_WD)) ptw_if ();

   itlb_refill_ctrl #(
      .NUM_ENTRIES(NUM_ENTRIES),
      .ASID_WD    (ASID_WD),
      .VPN_WD     (VPN_WD),
      .PPN_WD     (PPN_WD)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .tlb_flush_i   (tlb_flush),
      .lookup_valid_i(lookup_valid),
      .lookup_asid_i (lookup_asid),
      .lookup_vpn_i  (lookup_vpn),
      .hit_vec_i     (hit_vec),
      .valid_vec_i   (valid_vec),
      .busy_o        (busy),
      .ptw           (ptw_if),
      .fill_we_o     (fill_we),
      .fill_asid_o   (fill_asid),
      .fill_vpn_o    (fill_vpn),
      .fill_ppn_o    (fill_ppn),
      .fill_g_o      (fill_g),
      .fault_o       (fault)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Enter at a falling edge in IDLE; leave at the falling edge where REQ is visible.
   task automatic miss(input logic [ASID_WD-1:0] asid, input logic [VPN_WD-1:0] vpn);
      lookup_valid = 1'b1;
      lookup_asid  = asid;
      lookup_vpn   = vpn;
      hit_vec      = '0;
      tick();
      lookup_valid = 1'b0;
   endtask

   // Enter in REQ; leave at the falling edge where WAIT is visible.
   task automatic handshake();
      ptw_if.ptw_req_ready = 1'b1;
      tick();
      ptw_if.ptw_req_ready = 1'b0;
   endtask

   // Enter in WAIT; leave at the falling edge one cycle after the response pulse.
   task automatic respond(input logic [PPN_WD-1:0] ppn, input logic g, input logic flt);
      ptw_if.ptw_resp_valid = 1'b1;
      ptw_if.ptw_resp_ppn   = ppn;
      ptw_if.ptw_resp_g     = g;
      ptw_if.ptw_resp_fault = flt;
      tick();
      ptw_if.ptw_resp_valid = 1'b0;
      ptw_if.ptw_resp_fault = 1'b0;
   endtask

   initial begin
      rst                   = 1'b1;
      tlb_flush             = 1'b0;
      lookup_valid          = 1'b0;
      lookup_asid           = '0;
      lookup_vpn            = '0;
      hit_vec               = '0;
      valid_vec             = '0;
      ptw_if.ptw_req_ready  = 1'b0;
      ptw_if.ptw_resp_valid = 1'b0;
      ptw_if.ptw_resp_ppn   = '0;
      ptw_if.ptw_resp_g     = 1'b0;
      ptw_if.ptw_resp_fault = 1'b0;
      tick();
      tick();
      #1;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_req_valid", ptw_if.ptw_req_valid, 0);
      check_eq("rst_fill_we", fill_we, 0);
      check_eq("rst_fault", fault, 0);
      check_eq("rst_req_vpn", ptw_if.ptw_req_vpn, 0);
      rst = 1'b0;
      tick();

      // Basic miss -> walk -> fill into first invalid line.
      valid_vec = 8'h00;
      miss(9'd2, 20'h004FF);
      #1;
      check_eq("t1_req_valid", ptw_if.ptw_req_valid, 1);
      check_eq("t1_req_asid", ptw_if.ptw_req_asid, 2);
      check_eq("t1_req_vpn", ptw_if.ptw_req_vpn, 20'h004FF);
      check_eq("t1_busy", busy, 1);
      handshake();
      #1;
      check_eq("t1_req_dropped", ptw_if.ptw_req_valid, 0);
      tick();
      respond(22'h1234, 1'b0, 1'b0);
      #1;
      check_eq("t1_fill_we", fill_we, 8'h01);
      check_eq("t1_fill_vpn", fill_vpn, 20'h004FF);
      check_eq("t1_fill_ppn", fill_ppn, 22'h1234);
      check_eq("t1_fill_asid", fill_asid, 2);
      check_eq("t1_fill_g", fill_g, 0);
      tick();
      #1;
      check_eq("t1_fill_done", fill_we, 0);
      check_eq("t1_idle", busy, 0);

      // All lines valid: round-robin victims, wrapping after the last line.
      valid_vec = 8'hFF;
      for (int i = 0; i < 9; i++) begin
         miss(9'd3, VPN_WD'(20'h10000 + i));
         handshake();
         respond(22'h2000, 1'b1, 1'b0);
         #1;
         check_eq($sformatf("t2_victim%0d", i), fill_we, 8'h01 << (i % 8));
         tick();
      end

      // Backpressured request is held stable for four cycles, one handshake.
      valid_vec = 8'hF7;
      miss(9'd5, 20'hABCDE);
      for (int i = 0; i < 3; i++) begin
         #1;
         check_eq($sformatf("t3_hold%0d", i), ptw_if.ptw_req_valid, 1);
         check_eq($sformatf("t3_vpn%0d", i), ptw_if.ptw_req_vpn, 20'hABCDE);
         tick();
      end
      #1;
      check_eq("t3_hold3", ptw_if.ptw_req_valid, 1);
      handshake();
      #1;
      check_eq("t3_one_hs", ptw_if.ptw_req_valid, 0);
      check_eq("t3_wait_busy", busy, 1);
      respond(22'h3FFFFF, 1'b1, 1'b0);
      #1;
      check_eq("t3_fill_we", fill_we, 8'h08);
      check_eq("t3_fill_g", fill_g, 1);
      tick();

      // Walk fault: one-cycle fault pulse, no write.
      miss(9'd1, 20'h00042);
      handshake();
      respond(22'h0, 1'b0, 1'b1);
      #1;
      check_eq("t4_fault", fault, 1);
      check_eq("t4_no_fill", fill_we, 0);
      check_eq("t4_busy", busy, 0);
      tick();
      #1;
      check_eq("t4_fault_pulse", fault, 0);

      // Flush in WAIT drops the walk and resets the round-robin pointer (was 1).
      valid_vec = 8'hFF;
      miss(9'd1, 20'h00077);
      handshake();
      tlb_flush = 1'b1;
      tick();
      tlb_flush = 1'b0;
      respond(22'h55, 1'b0, 1'b0);
      #1;
      check_eq("t5_no_fill", fill_we, 0);
      check_eq("t5_no_fault", fault, 0);
      check_eq("t5_idle", busy, 0);
      tick();
      #1;
      check_eq("t5_no_fill_late", fill_we, 0);
      miss(9'd1, 20'h00078);
      handshake();
      respond(22'h56, 1'b0, 1'b0);
      #1;
      check_eq("t5_rr_reset", fill_we, 8'h01);
      tick();

      // Flush in REQ also suppresses a faulting walk's fault pulse.
      miss(9'd1, 20'h00079);
      tlb_flush = 1'b1;
      #1;
      check_eq("t5_req_kept", ptw_if.ptw_req_valid, 1);
      tick();
      tlb_flush = 1'b0;
      #1;
      check_eq("t5_req_not_withdrawn", ptw_if.ptw_req_valid, 1);
      handshake();
      respond(22'h0, 1'b0, 1'b1);
      #1;
      check_eq("t5_fault_dropped", fault, 0);
      check_eq("t5_drop_idle", busy, 0);
      tick();

      // Multi-hit and flushed lookups never start a walk.
      lookup_valid = 1'b1;
      hit_vec      = 8'h0C;
      tick();
      #1;
      check_eq("t6_hit_no_req", ptw_if.ptw_req_valid, 0);
      check_eq("t6_hit_busy", busy, 0);
      hit_vec   = 8'h00;
      tlb_flush = 1'b1;
      tick();
      lookup_valid = 1'b0;
      tlb_flush    = 1'b0;
      #1;
      check_eq("t6_flush_no_req", ptw_if.ptw_req_valid, 0);
      check_eq("t6_flush_busy", busy, 0);

      // Flush during the FILL cycle masks the write enable.
      miss(9'd4, 20'h00100);
      handshake();
      respond(22'h99, 1'b0, 1'b0);
      tlb_flush = 1'b1;
      #1;
      check_eq("t6_fill_masked", fill_we, 0);
      tick();
      tlb_flush = 1'b0;
      #1;
      check_eq("t6_fill_masked_idle", busy, 0);

      // Reset in WAIT clears everything; a late response is ignored.
      miss(9'd6, 20'h00200);
      handshake();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check_eq("t6_rst_busy", busy, 0);
      check_eq("t6_rst_req_vpn", ptw_if.ptw_req_vpn, 0);
      check_eq("t6_rst_fill_vpn", fill_vpn, 0);
      respond(22'h123, 1'b1, 1'b0);
      #1;
      check_eq("t6_late_no_fill", fill_we, 0);
      check_eq("t6_late_busy", busy, 0);
      check_eq("t6_late_ppn", fill_ppn, 0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
